// File: rtl/spi_master.sv
// SPI mode-0 initiator: one-cycle start -> 16-bit {addr, rw, data} frame, MSB first.
// Latency: done pulses in the cycle after edge 35*HALF_PERIOD, counting the accept edge as 0.
// Backpressure: start is accepted only while ready=1; requests in any other state are dropped.
//
// Ports:
//   clk, reset          system clock, async active-high reset
//   start, rw           request strobe (sampled only while ready) and direction (1 = read)
//   addr, wdata         7-bit address and 8-bit write data, captured with start
//   ready, done, rdata  idle flag, completion pulse, last byte read
//   sclk_pin, cs_pin,   SPI clock (idle low), chip select (active low)
//   mosi_pin, miso_pin  serial data out / in (miso sampled raw)
module spi_master #(
  parameter int HALF_PERIOD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);

  localparam int CW = $clog2(2 * HALF_PERIOD);
  // Phase counters are loaded with (length - 1) and the phase ends when they reach 0.
  localparam logic [CW-1:0] LP_HALF = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] LP_GAP  = CW'(2 * HALF_PERIOD - 1);
  localparam logic [CW-1:0] LP_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_GAP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_phase;
  logic [4:0]    r_bit;
  logic [15:0]   r_tx;
  // Seven bits suffice: the eighth data bit arrives on the final capture and goes
  // straight into rdata together with the seven already shifted in.
  logic [6:0]    r_rx;
  logic          r_rw;
  logic          r_ready;
  logic          r_done;
  logic [7:0]    r_rdata;
  logic          r_sclk;
  logic          r_cs;
  logic          r_mosi;

  logic          w_phase_end;
  logic          w_capture;
  logic          w_last_bit;
  logic [7:0]    w_rx_next;

  assign w_phase_end = (r_phase == '0);
  // In HIGH the bit counter is 0..15, so bit 3 marks the data half (bits 8..15).
  assign w_capture   = r_rw && r_bit[3];
  assign w_last_bit  = (r_bit == 5'd15);
  assign w_rx_next   = {r_rx, miso_pin};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_bit   <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_rw    <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_rdata <= '0;
      r_sclk  <= 1'b0;
      r_cs    <= 1'b1;
      r_mosi  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // Reads shift out zeros in the data byte; the slave owns miso then.
            r_tx    <= {addr, rw, (rw ? 8'h00 : wdata)};
            r_rw    <= rw;
            r_mosi  <= addr[6];
            r_cs    <= 1'b0;
            r_ready <= 1'b0;
            r_bit   <= '0;
            r_phase <= LP_HALF;
            r_state <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (w_phase_end) begin
            r_sclk  <= 1'b1;
            r_phase <= LP_HALF;
            r_state <= S_HIGH;
          end else begin
            r_phase <= r_phase - LP_ONE;
          end
        end

        S_HIGH: begin
          if (w_phase_end) begin
            r_sclk  <= 1'b0;
            r_phase <= LP_HALF;
            r_bit   <= r_bit + 5'd1;
            // Zeros shift in from the bottom, so after the 16th bit mosi idles at 0.
            r_tx    <= {r_tx[14:0], 1'b0};
            r_mosi  <= r_tx[14];
            if (w_capture) begin
              r_rx <= w_rx_next[6:0];
              if (w_last_bit) begin
                r_rdata <= w_rx_next;
              end
            end
            r_state <= S_LOW;
          end else begin
            r_phase <= r_phase - LP_ONE;
          end
        end

        S_LOW: begin
          if (w_phase_end) begin
            if (r_bit == 5'd16) begin
              // This LOW was the hold phase after the last bit.
              r_cs    <= 1'b1;
              r_phase <= LP_GAP;
              r_state <= S_GAP;
            end else begin
              r_sclk  <= 1'b1;
              r_phase <= LP_HALF;
              r_state <= S_HIGH;
            end
          end else begin
            r_phase <= r_phase - LP_ONE;
          end
        end

        S_GAP: begin
          if (w_phase_end) begin
            r_ready <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_phase <= r_phase - LP_ONE;
          end
        end

        default: begin
          r_sclk  <= 1'b0;
          r_cs    <= 1'b1;
          r_mosi  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready    = r_ready;
  assign done     = r_done;
  assign rdata    = r_rdata;
  assign sclk_pin = r_sclk;
  assign cs_pin   = r_cs;
  assign mosi_pin = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       sel;   // 0: HALF_PERIOD=4 instance, 1: HALF_PERIOD=2 instance

  logic       a_start, a_ready, a_done, a_sclk, a_cs, a_mosi;
  logic [7:0] a_rdata;
  logic       b_start, b_ready, b_done, b_sclk, b_cs, b_mosi;
  logic [7:0] b_rdata;

  logic       m_ready, m_done, m_sclk, m_cs, m_mosi;
  logic [7:0] m_rdata;
  logic       s_miso;

  always #5 clk = ~clk;

  assign a_start = start & ~sel;
  assign b_start = start & sel;

  spi_master #(.HALF_PERIOD(4)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .rw(rw), .addr(addr), .wdata(wdata),
    .ready(a_ready), .done(a_done), .rdata(a_rdata),
    .sclk_pin(a_sclk), .cs_pin(a_cs), .mosi_pin(a_mosi), .miso_pin(s_miso)
  );

  spi_master #(.HALF_PERIOD(2)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .rw(rw), .addr(addr), .wdata(wdata),
    .ready(b_ready), .done(b_done), .rdata(b_rdata),
    .sclk_pin(b_sclk), .cs_pin(b_cs), .mosi_pin(b_mosi), .miso_pin(s_miso)
  );

  assign m_ready = sel ? b_ready : a_ready;
  assign m_done  = sel ? b_done  : a_done;
  assign m_rdata = sel ? b_rdata : a_rdata;
  assign m_sclk  = sel ? b_sclk  : a_sclk;
  assign m_cs    = sel ? b_cs    : a_cs;
  assign m_mosi  = sel ? b_mosi  : a_mosi;

  // Behavioral SPI memory slave: samples mosi on SCLK rise, drives miso on SCLK fall.
  logic [7:0]  mem [128];
  logic [15:0] s_frame = '0;
  int          s_cnt = 0;
  logic [6:0]  s_addr = '0;
  logic        s_rw = 1'b0;

  always @(negedge m_cs) begin
    s_cnt   = 0;
    s_frame = '0;
    s_miso  = 1'b0;
  end

  always @(posedge m_sclk) begin
    if (!m_cs && s_cnt < 16) begin
      s_frame = {s_frame[14:0], m_mosi};
      s_cnt++;
      if (s_cnt == 8) begin
        s_addr = s_frame[7:1];
        s_rw   = s_frame[0];
      end
      if (s_cnt == 16 && !s_rw) mem[s_addr] = s_frame[7:0];
    end
  end

  always @(negedge m_sclk) begin
    if (!m_cs && s_rw && s_cnt >= 8 && s_cnt < 16) s_miso = mem[s_addr][15 - s_cnt];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Transaction monitor state; times are in clk edges after the accept edge.
  int   base;
  int   n_rise, rise1, rise2, rise_last, cs_rise_e, done_e, n_done;
  logic p_sclk, p_cs;

  task automatic xfer_begin(input logic i_rw, input logic [6:0] i_a, input logic [7:0] i_d);
    int w = 0;
    while (!m_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!m_ready) check("ready_wait", 32'(m_ready), 32'd1);
    rw = i_rw; addr = i_a; wdata = i_d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base = cyc;
    n_rise = 0; rise1 = -1; rise2 = -1; rise_last = -1;
    cs_rise_e = -1; done_e = -1; n_done = 0;
    p_sclk = m_sclk; p_cs = m_cs;
  endtask

  task automatic watch(input int upto_e, input int stop_rise, input int poke_rise);
    bit poked = 1'b0;
    while (cyc - base < upto_e) begin
      @(negedge clk);
      if (start && poked) start = 1'b0;
      if (m_sclk && !p_sclk) begin
        n_rise++;
        if (n_rise == 1) rise1 = cyc - base;
        if (n_rise == 2) rise2 = cyc - base;
        rise_last = cyc - base;
      end
      if (m_cs && !p_cs && cs_rise_e < 0) cs_rise_e = cyc - base;
      if (m_done) begin
        n_done++;
        if (done_e < 0) done_e = cyc - base;
      end
      p_sclk = m_sclk;
      p_cs   = m_cs;
      if (poke_rise > 0 && !poked && n_rise == poke_rise && m_sclk) begin
        start = 1'b1; rw = 1'b0; addr = 7'h01;
        poked = 1'b1;
      end
      if (stop_rise > 0 && n_rise >= stop_rise) break;
    end
  endtask

  task automatic check_txn(input string nm, input int h, input logic [15:0] frame,
                           input logic [7:0] rd);
    check({nm, "_frame"},   32'(s_frame),   32'(frame));
    check({nm, "_nrise"},   n_rise,         16);
    check({nm, "_rise1"},   rise1,          h);
    check({nm, "_rise16"},  rise_last,      31 * h);
    check({nm, "_cs_rise"}, cs_rise_e,      33 * h);
    check({nm, "_done_at"}, done_e,         35 * h);
    check({nm, "_ndone"},   n_done,         1);
    check({nm, "_rdata"},   32'(m_rdata),   32'(rd));
    check({nm, "_ready"},   32'(m_ready),   32'd1);
  endtask

  int hi_cnt, gap_cnt;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[7'h7F] = 8'h3C;
    sel = 1'b0; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_ready", 32'(m_ready), 32'd1);
    check("rst_done",  32'(m_done),  32'd0);
    check("rst_cs",    32'(m_cs),    32'd1);
    check("rst_sclk",  32'(m_sclk),  32'd0);
    check("rst_mosi",  32'(m_mosi),  32'd0);
    check("rst_rdata", 32'(m_rdata), 32'd0);

    // Write 0xA5 to 0x15, H=4: frame 0x2AA5, CS high again at edge 132, done after 140
    xfer_begin(1'b0, 7'h15, 8'hA5);
    check("wr_cs_low",   32'(m_cs),    32'd0);
    check("wr_not_rdy",  32'(m_ready), 32'd0);
    watch(35 * 4 + 3, 0, 0);
    check_txn("wr", 4, 16'h2AA5, 8'h00);

    // Read 0x7F, slave returns 0x3C: frame 0xFF00
    xfer_begin(1'b1, 7'h7F, 8'hEE);
    watch(35 * 4 + 3, 0, 0);
    check_txn("rd", 4, 16'hFF00, 8'h3C);

    // Busy: request during HIGH of the 6th bit is ignored; rdata stays 0x3C
    xfer_begin(1'b0, 7'h15, 8'hA5);
    watch(40 * 4, 0, 6);
    check_txn("busy", 4, 16'h2AA5, 8'h3C);

    // Reset during bit 10 of a write
    xfer_begin(1'b0, 7'h11, 8'h22);
    watch(40 * 4, 11, 0);
    check("abort_reached_bit10", n_rise, 11);
    #2 reset = 1'b1;
    #1;
    check("abort_cs",    32'(m_cs),    32'd1);
    check("abort_sclk",  32'(m_sclk),  32'd0);
    check("abort_ready", 32'(m_ready), 32'd1);
    check("abort_rdata", 32'(m_rdata), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    base = cyc; n_done = 0;
    watch(40 * 4, 0, 0);
    check("abort_no_done", n_done, 0);

    // Normal write after the abort
    xfer_begin(1'b0, 7'h02, 8'h5A);
    watch(35 * 4 + 3, 0, 0);
    check_txn("post_abort", 4, 16'h045A, 8'h00);

    // Loopback: start held high; write 0x99 to 0x33, then read 0x33 back
    while (!m_ready) @(negedge clk);
    rw = 1'b0; addr = 7'h33; wdata = 8'h99; start = 1'b1;
    @(negedge clk);
    rw = 1'b1;   // captured only at the next accept
    base = cyc; n_done = 0; hi_cnt = 0; gap_cnt = 0;
    for (int i = 0; i < 80 * 4 && n_done < 2; i++) begin
      @(negedge clk);
      if (m_done) n_done++;
      if (m_cs && start) hi_cnt++;
      if (m_cs && start && !m_ready) gap_cnt++;
      if (n_done == 1 && !m_ready) start = 1'b0;
    end
    start = 1'b0;
    check("loop_two_done", n_done, 2);
    // GAP state is 2H cycles with CS high; the done/accept cycle adds one more.
    check("loop_gap",      gap_cnt, 2 * 4);
    check("loop_cs_high",  hi_cnt,  2 * 4 + 1);
    check("loop_rdata",    32'(m_rdata), 32'h99);
    check("loop_frame",    32'(s_frame), 32'h6700);
    base = cyc;
    watch(20, 0, 0);
    check("loop_no_third", n_done, 2);

    // Minimum divider, H=2: SCLK period 4, done after edge 70
    sel = 1'b1;
    @(negedge clk);
    xfer_begin(1'b0, 7'h15, 8'hA5);
    watch(35 * 2 + 3, 0, 0);
    check_txn("h2", 2, 16'h2AA5, 8'h00);
    check("h2_period", rise2 - rise1, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
